// File: rtl/uart_tx_mmio_if.sv
// Core data-bus slice seen by the UART window: strobes, address and write data in, registered read data out.
// Master is the core side; slave is the register block.
interface uart_tx_mmio_if;
    logic        iCE;
    logic        iRD;
    logic        iWR;
    logic [31:0] iADDR;
    logic [31:0] iDATA;
    logic [31:0] oDATA;

    modport master (output iCE, iRD, iWR, iADDR, iDATA, input oDATA);
    modport slave  (input iCE, iRD, iWR, iADDR, iDATA, output oDATA);
endinterface

// File: rtl/uart_tx_mmio.sv
// MMIO UART transmitter: bus writes fill a byte FIFO drained by an 8N1 serializer on oTXD; reads return 1 cycle later.
// No bus backpressure: a push into a full FIFO is dropped and latches a sticky overflow flag software can clear.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          CLK_DIV   = 434,
    parameter int          FIFO_LOG2 = 4
) (
    input  logic            iCLK,
    input  logic            iRST,
    uart_tx_mmio_if.slave   bus,
    output logic            oTXD,
    output logic            oBUSY,
    output logic            oIRQ
);
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int CW    = FIFO_LOG2 + 1;
    localparam int BCW   = $clog2(CLK_DIV);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]           r_mem [DEPTH];
    logic [FIFO_LOG2-1:0] r_wptr;
    logic [FIFO_LOG2-1:0] r_rptr;
    logic [CW-1:0]        r_count;
    logic                 r_ovf;
    logic                 r_irq_en;
    logic [31:0]          r_rdata;

    state_t               r_state;
    logic [BCW-1:0]       r_bitcnt;
    logic [2:0]           r_idx;
    logic [7:0]           r_shift;
    logic                 r_txd;

    logic                 w_hit;
    logic [1:0]           w_off;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push_req;
    logic                 w_push;
    logic                 w_ovf_set;
    logic                 w_ovf_clr;
    logic                 w_ctrl_wr;
    logic                 w_pop;
    logic                 w_bit_end;
    logic                 w_ser_busy;
    logic [7:0]           w_head;
    logic [31:0]          w_rd_val;
    logic                 w_unused;

    assign w_hit      = bus.iCE && (bus.iADDR[31:4] == BASE_ADDR[31:4]);
    assign w_off      = bus.iADDR[3:2];
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push_req = w_hit && bus.iWR && (w_off == 2'd0);
    // Fullness is judged before any same-cycle pop, so a push racing a pop on a full FIFO is still lost.
    assign w_push     = w_push_req && !w_full;
    assign w_ovf_set  = w_push_req && w_full;
    assign w_ovf_clr  = w_hit && bus.iWR && (w_off == 2'd1) && bus.iDATA[3];
    assign w_ctrl_wr  = w_hit && bus.iWR && (w_off == 2'd2);
    assign w_bit_end  = (r_bitcnt == BCW'(CLK_DIV - 1));
    assign w_ser_busy = (r_state != S_IDLE);
    assign w_head     = r_mem[r_rptr];
    assign w_pop      = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
    assign w_unused   = &{1'b0, bus.iADDR[1:0], bus.iDATA[31:8]};

    always_comb begin
        w_rd_val = '0;
        case (w_off)
            2'd1: begin
                w_rd_val[0]       = w_full;
                w_rd_val[1]       = w_empty;
                w_rd_val[2]       = w_ser_busy;
                w_rd_val[3]       = r_ovf;
                w_rd_val[8 +: CW] = r_count;
            end
            2'd2:    w_rd_val[0] = r_irq_en;
            default: w_rd_val = '0;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.iDATA[7:0];
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_irq_en <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + FIFO_LOG2'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + FIFO_LOG2'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_ctrl_wr) begin
                r_irq_en <= bus.iDATA[0];
            end
            // w_rd_val is built from pre-edge state, so a combined read+write returns the old value.
            r_rdata <= (w_hit && bus.iRD) ? w_rd_val : 32'd0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state  <= S_IDLE;
            r_bitcnt <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_txd    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_txd    <= 1'b1;
                    r_bitcnt <= '0;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_state <= S_START;
                        r_txd   <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_bitcnt <= '0;
                        r_idx    <= '0;
                        r_state  <= S_DATA;
                        r_txd    <= r_shift[0];
                    end else begin
                        r_bitcnt <= r_bitcnt + BCW'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_bitcnt <= '0;
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_txd   <= 1'b1;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_shift <= r_shift >> 1;
                            r_txd   <= r_shift[1];
                        end
                    end else begin
                        r_bitcnt <= r_bitcnt + BCW'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_bitcnt <= '0;
                        // Chain straight into the next start bit when more data is queued.
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_state <= S_START;
                            r_txd   <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_txd   <= 1'b1;
                        end
                    end else begin
                        r_bitcnt <= r_bitcnt + BCW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.oDATA = r_rdata;
    assign oTXD      = r_txd;
    assign oBUSY     = w_ser_busy || !w_empty;
    assign oIRQ      = r_irq_en && !oBUSY;
endmodule
